// File: rtl/fetch_decode_sequencer.sv
// Instruction front-end sequencer: fetches words over a request/ready port, holds them
// through the decoder's one-cycle latency, and issues to execute under valid/ready.
module fetch_decode_sequencer #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0,
  parameter int                    PC_STEP       = 4,
  parameter int                    FETCH_TIMEOUT = 255
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable,
  output logic                  MemRead,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  input  logic                  MemReady,
  input  logic [31:0]           MemData,
  output logic [31:0]           DecodeWord,
  output logic                  InstrValid,
  output logic [ADDR_WIDTH-1:0] InstrPC,
  input  logic                  ExecReady,
  input  logic                  Redirect,
  input  logic [ADDR_WIDTH-1:0] RedirectAddress,
  output logic                  Fault,
  output logic [31:0]           IssueCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_FAULT
  } state_t;

  localparam logic [8:0]            TIMEOUT_LIMIT = 9'(FETCH_TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] PC_INC        = ADDR_WIDTH'(PC_STEP);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic [8:0]              cnt_inc;
  logic [31:0]             word_reg, word_next;
  logic [31:0]             issue_reg, issue_next;

  // State and datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      cnt_reg   <= '0;
      word_reg  <= '0;
      issue_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
      issue_reg <= issue_next;
    end
  end

  assign cnt_inc = {1'b0, cnt_reg} + 9'd1;

  // Next-state logic; a redirect outranks memory and execute handshakes in every live state
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    word_next  = word_reg;
    issue_next = issue_reg;
    if (state_reg != S_FAULT && Redirect) begin
      pc_next    = RedirectAddress;
      cnt_next   = '0;
      state_next = Enable ? S_FETCH : S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (Enable) state_next = S_FETCH;
        end
        S_FETCH: begin
          if (MemReady) begin
            word_next  = MemData;
            cnt_next   = '0;
            state_next = S_DECODE;
          end else begin
            cnt_next = cnt_inc[7:0];
            if (FETCH_TIMEOUT != 0 && cnt_inc == TIMEOUT_LIMIT) state_next = S_FAULT;
          end
        end
        S_DECODE: begin
          state_next = S_ISSUE;
        end
        S_ISSUE: begin
          if (ExecReady) begin
            pc_next    = pc_reg + PC_INC;
            issue_next = issue_reg + 32'd1;
            state_next = Enable ? S_FETCH : S_IDLE;
          end
        end
        S_FAULT: begin
          state_next = S_FAULT;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs are pure functions of the registered state
  always_comb begin
    MemRead    = 1'b0;
    InstrValid = 1'b0;
    Fault      = 1'b0;
    case (state_reg)
      S_FETCH: MemRead    = 1'b1;
      S_ISSUE: InstrValid = 1'b1;
      S_FAULT: Fault      = 1'b1;
      default: ;
    endcase
  end

  assign MemAddress = pc_reg;
  assign InstrPC    = pc_reg;
  assign DecodeWord = word_reg;
  assign IssueCount = issue_reg;

endmodule
